// File: rtl/alu32_arbiter.sv
// Grants one of two requesters to the shared 32-bit ALU, registers its operands, captures the result and returns it.
// Macro ALU_ARB_RR_EN selects round-robin tie-breaking; when undefined requester 0 has fixed priority.
module alu32_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_m,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              gnt0;
    logic              gnt1;
    logic              gid;
    logic              err_q;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [3:0]        sel_op;
    logic              sel_legal;

`ifdef ALU_ARB_RR_EN
    logic              last_gnt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && !rst) begin
`ifdef ALU_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
`else
            gnt0 = req0_valid;
            gnt1 = req1_valid && !req0_valid;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt0 || gnt1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (gid ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the winner sees ready during a grant; with nothing pending both stay open.
    always_comb begin
        req0_ready = (state == IDLE) && !rst && !gnt1;
        req1_ready = (state == IDLE) && !rst && !gnt0;
        rsp0_valid = (state == RESP) && !gid;
        rsp1_valid = (state == RESP) && gid;
    end

    always_comb begin
        sel_a     = gnt1 ? req1_a  : req0_a;
        sel_b     = gnt1 ? req1_b  : req0_b;
        sel_op    = gnt1 ? req1_op : req0_op;
        sel_legal = !sel_op[3] || (sel_op == 4'b1110);
    end

    // NOTE: every register here is visible at a port or steers the FSM, so all of them are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_m    <= 4'b0000;
            gid      <= 1'b0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            if (gnt0 || gnt1) begin
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                alu_m    <= sel_legal ? sel_op : 4'b0000;
                err_q    <= !sel_legal;
                gid      <= gnt1;
`ifdef ALU_ARB_RR_EN
                last_gnt <= gnt1;
`endif
            end
            if (state == EXEC) begin
                rsp_data <= err_q ? '0 : alu_result;
                rsp_err  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_alu32_arbiter.sv
// Scoreboard bench for alu32_arbiter: the bench plays the shared ALU and predicts grants and responses from op semantics.
module tb_alu32_arbiter;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  m;
        int          issue_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_m;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   random_bp = 1'b0;
    exp_t q[2][$];
    bit   seen[2];
    bit   exec_pending = 1'b0;
    exp_t exec_item;
    bit   model_last = 1'b1;

    alu32_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
        logic [31:0] diff;
        diff = a - b;
        case (m)
            4'd0:    return a | b;
            4'd1:    return a & b;
            4'd2:    return a ^ b;
            4'd3:    return a + b;
            4'd4:    return ~(a | b);
            4'd5:    return ~(a & b);
            4'd6:    return {31'd0, diff[31]};
            4'd7:    return diff;
            4'd14:   return {31'd0, ~diff[31]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit op_legal(input logic [3:0] m);
        return (m <= 4'd7) || (m == 4'd14);
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_m);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (random_bp) begin
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic mon_rsp(input int id, input logic v, input logic r);
        exp_t it;
        if (!v) return;
        if (q[id].size() == 0) begin
            check($sformatf("rsp%0d_unexpected_valid", id), 32'(v), 32'd0);
            return;
        end
        it = q[id][0];
        if (!seen[id]) begin
            check($sformatf("rsp%0d_latency", id), 32'(cyc - it.issue_cyc), 32'd2);
            seen[id] = 1'b1;
        end
        check($sformatf("rsp%0d_data", id), rsp_data, it.data);
        check($sformatf("rsp%0d_err", id), 32'(rsp_err), 32'(it.err));
        check($sformatf("rsp%0d_req_ready_low", id), 32'({req0_ready, req1_ready}), 32'd0);
        if (r) begin
            void'(q[id].pop_front());
            seen[id] = 1'b0;
        end
    endtask

    // Monitor: observes grants and responses, compares against the bench's own predictions.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            q[0].delete();
            q[1].delete();
            seen[0] = 1'b0;
            seen[1] = 1'b0;
            exec_pending = 1'b0;
            model_last = 1'b1;
        end else begin
            bit   h0, h1, win, exp_win;
            exp_t it;
            if (exec_pending) begin
                check("exec_alu_a", alu_a, exec_item.a);
                check("exec_alu_b", alu_b, exec_item.b);
                check("exec_alu_m", 32'(alu_m), 32'(exec_item.m));
                exec_pending = 1'b0;
            end
            if (rsp0_valid && rsp1_valid) check("rsp_both_valid", 32'd1, 32'd0);
            mon_rsp(0, rsp0_valid, rsp0_ready);
            mon_rsp(1, rsp1_valid, rsp1_ready);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            if (h0 || h1) begin
                if (h0 && h1) check("single_grant", 32'd2, 32'd1);
                win = h1 && !h0;
                if (req0_valid && req1_valid) exp_win = RR ? !model_last : 1'b0;
                else exp_win = req1_valid;
                check("grant_winner", 32'(win), 32'(exp_win));
                it.a = win ? req1_a : req0_a;
                it.b = win ? req1_b : req0_b;
                it.m = win ? req1_op : req0_op;
                it.err = !op_legal(it.m);
                it.data = it.err ? 32'd0 : alu_fn(it.a, it.b, it.m);
                if (it.err) it.m = 4'd0;
                it.issue_cyc = cyc;
                q[win].push_back(it);
                exec_item = it;
                exec_pending = 1'b1;
                model_last = win;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that completes the handshake.
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n = 0;
        bit ok = 1'b0;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        while (!ok && n < 2000) begin
            @(negedge clk);
            n++;
            ok = (id == 0) ? req0_ready : req1_ready;
        end
        if (!ok) check($sformatf("req%0d_handshake_timeout", id), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q[0].size() + q[1].size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_stream(input int id, input int count);
        for (int i = 0; i < count; i++) begin
            logic [31:0] a, b;
            a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
            b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(id, a, b, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        int n;
        // Reset held with a request pending: nothing may be granted.
        req0_valid = 1'b1;
        req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_m", 32'(alu_m), 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready_both", 32'({req0_ready, req1_ready}), 32'd3);
        @(posedge clk);
        #1;

        // Directed operations.
        send(0, 32'd7, 32'd9, 4'b0011);
        drain();
        send(1, 32'd5, 32'd7, 4'b0111);
        drain();
        send(0, 32'd3, 32'd5, 4'b0110);
        drain();
        send(1, 32'd3, 32'd5, 4'b1110);
        drain();
        send(0, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1010);
        drain();
        check("sub_result_seen", rsp_data, 32'd0);

        // Both requesters continuously valid, four ops each.
        fork
            for (int i = 0; i < 4; i++) send(0, 32'(i * 3), 32'd11, 4'd3);
            for (int i = 0; i < 4; i++) send(1, 32'(i * 5), 32'd2, 4'd7);
        join
        drain();

        // Randomized traffic with random response backpressure.
        random_bp = 1'b1;
        fork
            rand_stream(0, 30);
            rand_stream(1, 30);
        join
        drain();
        random_bp = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(posedge clk);
        #1;

        // Backpressure hold, then reset while in RESP.
        rsp0_ready = 1'b0;
        send(0, 32'h0000_1234, 32'h0000_1111, 4'b0011);
        n = 0;
        while (!rsp0_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp0_valid_seen", 32'(rsp0_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp_data_hold", rsp_data, 32'h0000_2345);
            check("bp_rsp0_valid_hold", 32'(rsp0_valid), 32'd1);
            check("bp_req_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("post_rst_rsp_data", rsp_data, 32'd0);
        check("post_rst_rsp_err", 32'(rsp_err), 32'd0);
        check("post_rst_alu_a", alu_a, 32'd0);
        check("post_rst_alu_b", alu_b, 32'd0);
        check("post_rst_alu_m", 32'(alu_m), 32'd0);
        check("post_rst_ready", 32'({req0_ready, req1_ready}), 32'd3);
        rsp0_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_rsp", 32'(rsp0_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // After reset requester 0 wins the first tie under either policy.
        fork
            send(0, 32'd1, 32'd1, 4'd2);
            send(1, 32'd2, 32'd1, 4'd7);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
